// File: rtl/axi_pkt_pkg.sv
// Packet layouts shared by the master ingress packer and the master interface unpacker.
package axi_pkt_pkg;

  localparam int AXI_IDS_BITS = 8;
  localparam int AX_PKT_W     = 49;
  localparam int W_PKT_W      = 37;

  localparam int AX_ID_MSB    = 48;
  localparam int AX_ID_LSB    = 41;
  localparam int AX_ADDR_MSB  = 40;
  localparam int AX_ADDR_LSB  = 9;
  localparam int AX_LEN_MSB   = 8;
  localparam int AX_LEN_LSB   = 5;
  localparam int AX_SIZE_MSB  = 4;
  localparam int AX_SIZE_LSB  = 2;
  localparam int AX_BURST_MSB = 1;
  localparam int AX_BURST_LSB = 0;

  localparam int W_DATA_MSB   = 36;
  localparam int W_DATA_LSB   = 5;
  localparam int W_STRB_MSB   = 4;
  localparam int W_STRB_LSB   = 1;
  localparam int W_LAST_BIT   = 0;

  typedef struct packed {
    logic [AXI_IDS_BITS-1:0] id;
    logic [31:0]             addr;
    logic [3:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_ax_pkt_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_pkt_t;

endpackage

// File: rtl/sync_fifo.sv
// Small register-array FIFO; occupancy is tracked by an explicit count so
// full/empty never depend on pointer equality.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Memory is cleared on reset so the arbiter-facing data reads zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

endmodule

// File: rtl/axi_m_ingress.sv
// Per-master ingress: tags IDs, packs AR/AW/W into FIFOs, and holds W beats
// back from the arbiter until their AW has been granted.
module axi_m_ingress
  import axi_pkt_pkg::*;
#(
  parameter logic [3:0] MASTER_ID   = 4'h0,
  parameter int         DEPTH       = 4,
  parameter int         CREDIT_BITS = 4
) (
  input  logic                AXI_CLK_i,
  input  logic                AXI_RST_i,
  input  logic [3:0]          ARID_i,
  input  logic [31:0]         ARADDR_i,
  input  logic [3:0]          ARLEN_i,
  input  logic [2:0]          ARSIZE_i,
  input  logic [1:0]          ARBURST_i,
  input  logic                ARVALID_i,
  output logic                ARREADY_o,
  input  logic [3:0]          AWID_i,
  input  logic [31:0]         AWADDR_i,
  input  logic [3:0]          AWLEN_i,
  input  logic [2:0]          AWSIZE_i,
  input  logic [1:0]          AWBURST_i,
  input  logic                AWVALID_i,
  output logic                AWREADY_o,
  input  logic [31:0]         WDATA_i,
  input  logic [3:0]          WSTRB_i,
  input  logic                WLAST_i,
  input  logic                WVALID_i,
  output logic                WREADY_o,
  output logic                AR_FIFO_VALID_o,
  output logic [AX_PKT_W-1:0] AR_FIFO_DATA_o,
  input  logic                AR_FIFO_GRANT_i,
  output logic                AW_FIFO_VALID_o,
  output logic [AX_PKT_W-1:0] AW_FIFO_DATA_o,
  input  logic                AW_FIFO_GRANT_i,
  output logic                W_FIFO_VALID_o,
  output logic [W_PKT_W-1:0]  W_FIFO_DATA_o,
  input  logic                W_FIFO_GRANT_i
);

  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

  axi_ax_pkt_t ar_pkt, aw_pkt;
  axi_w_pkt_t  w_pkt, w_head;
  logic ar_full, ar_empty, aw_full, aw_empty, w_full, w_empty;
  logic ar_pop, aw_pop, w_pop, w_last_pop;
  logic [CREDIT_BITS-1:0] aw_credit_q, aw_credit_d;

  assign ar_pkt = '{id: {MASTER_ID, ARID_i}, addr: ARADDR_i, len: ARLEN_i,
                    size: ARSIZE_i, burst: ARBURST_i};
  assign aw_pkt = '{id: {MASTER_ID, AWID_i}, addr: AWADDR_i, len: AWLEN_i,
                    size: AWSIZE_i, burst: AWBURST_i};
  assign w_pkt  = '{data: WDATA_i, strb: WSTRB_i, last: WLAST_i};
  assign w_head = axi_w_pkt_t'(W_FIFO_DATA_o);

  assign ARREADY_o = !ar_full;
  assign AWREADY_o = !aw_full;
  assign WREADY_o  = !w_full;

  assign AR_FIFO_VALID_o = !ar_empty;
  assign AW_FIFO_VALID_o = !aw_empty && (aw_credit_q != CREDIT_MAX);
  assign W_FIFO_VALID_o  = !w_empty && (aw_credit_q != '0);

  assign ar_pop     = AR_FIFO_GRANT_i && AR_FIFO_VALID_o;
  assign aw_pop     = AW_FIFO_GRANT_i && AW_FIFO_VALID_o;
  assign w_pop      = W_FIFO_GRANT_i && W_FIFO_VALID_o;
  assign w_last_pop = w_pop && w_head.last;

  // Credit counts AWs that have left for the arbiter but whose burst has not closed.
  always_comb begin
    aw_credit_d = aw_credit_q;
    case ({aw_pop, w_last_pop})
      2'b10:   aw_credit_d = aw_credit_q + CREDIT_BITS'(1);
      2'b01:   aw_credit_d = aw_credit_q - CREDIT_BITS'(1);
      default: aw_credit_d = aw_credit_q;
    endcase
  end

  always_ff @(posedge AXI_CLK_i or posedge AXI_RST_i) begin
    if (AXI_RST_i) aw_credit_q <= '0;
    else           aw_credit_q <= aw_credit_d;
  end

  sync_fifo #(.WIDTH(AX_PKT_W), .DEPTH(DEPTH)) u_ar_fifo (
    .clk_i(AXI_CLK_i), .rst_i(AXI_RST_i),
    .push_i(ARVALID_i), .din_i(ar_pkt), .pop_i(ar_pop),
    .dout_o(AR_FIFO_DATA_o), .full_o(ar_full), .empty_o(ar_empty)
  );

  sync_fifo #(.WIDTH(AX_PKT_W), .DEPTH(DEPTH)) u_aw_fifo (
    .clk_i(AXI_CLK_i), .rst_i(AXI_RST_i),
    .push_i(AWVALID_i), .din_i(aw_pkt), .pop_i(aw_pop),
    .dout_o(AW_FIFO_DATA_o), .full_o(aw_full), .empty_o(aw_empty)
  );

  sync_fifo #(.WIDTH(W_PKT_W), .DEPTH(DEPTH)) u_w_fifo (
    .clk_i(AXI_CLK_i), .rst_i(AXI_RST_i),
    .push_i(WVALID_i), .din_i(w_pkt), .pop_i(w_pop),
    .dout_o(W_FIFO_DATA_o), .full_o(w_full), .empty_o(w_empty)
  );

endmodule

// File: tb/tb_axi_m_ingress.sv
// Directed bench for axi_m_ingress: AR packing table plus hand-written
// sequences for W/AW credit ordering, full FIFO, saturation and reset.
module tb_axi_m_ingress;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ARID_i = '0, AWID_i = '0, ARLEN_i = '0, AWLEN_i = '0, WSTRB_i = '0;
  logic [31:0] ARADDR_i = '0, AWADDR_i = '0, WDATA_i = '0;
  logic [2:0]  ARSIZE_i = '0, AWSIZE_i = '0;
  logic [1:0]  ARBURST_i = '0, AWBURST_i = '0;
  logic        ARVALID_i = 0, AWVALID_i = 0, WVALID_i = 0, WLAST_i = 0;
  logic        ARREADY_o, AWREADY_o, WREADY_o;
  logic        AR_FIFO_VALID_o, AW_FIFO_VALID_o, W_FIFO_VALID_o;
  logic [48:0] AR_FIFO_DATA_o, AW_FIFO_DATA_o;
  logic [36:0] W_FIFO_DATA_o;
  logic        AR_FIFO_GRANT_i = 0, AW_FIFO_GRANT_i = 0, W_FIFO_GRANT_i = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_m_ingress #(.MASTER_ID(4'h1), .DEPTH(4), .CREDIT_BITS(4)) dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst),
    .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
    .ARBURST_i(ARBURST_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
    .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i), .AWSIZE_i(AWSIZE_i),
    .AWBURST_i(AWBURST_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i),
    .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
    .AR_FIFO_VALID_o(AR_FIFO_VALID_o), .AR_FIFO_DATA_o(AR_FIFO_DATA_o),
    .AR_FIFO_GRANT_i(AR_FIFO_GRANT_i),
    .AW_FIFO_VALID_o(AW_FIFO_VALID_o), .AW_FIFO_DATA_o(AW_FIFO_DATA_o),
    .AW_FIFO_GRANT_i(AW_FIFO_GRANT_i),
    .W_FIFO_VALID_o(W_FIFO_VALID_o), .W_FIFO_DATA_o(W_FIFO_DATA_o),
    .W_FIFO_GRANT_i(W_FIFO_GRANT_i)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [48:0] exp;
  } ar_vec_t;

  ar_vec_t ar_tab[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_drive(input logic v, input logic [3:0] id, input logic [31:0] addr);
    ARVALID_i = v; ARID_i = id; ARADDR_i = addr; ARLEN_i = 4'h1; ARSIZE_i = 3'h2; ARBURST_i = 2'h1;
  endtask

  task automatic aw_drive(input logic v, input logic [3:0] id, input logic [31:0] addr);
    AWVALID_i = v; AWID_i = id; AWADDR_i = addr; AWLEN_i = 4'h3; AWSIZE_i = 3'h2; AWBURST_i = 2'h1;
  endtask

  task automatic w_drive(input logic v, input logic [31:0] d, input logic last);
    WVALID_i = v; WDATA_i = d; WSTRB_i = 4'hF; WLAST_i = last;
  endtask

  function automatic logic [48:0] ar_word(input logic [3:0] id, input logic [31:0] addr);
    return {4'h1, id, addr, 4'h1, 3'h2, 2'h1};
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    ar_tab[0] = '{4'h3, 32'h0000_1000, 4'h3, 3'h2, 2'h1, {8'h13, 32'h0000_1000, 4'h3, 3'h2, 2'h1}};
    ar_tab[1] = '{4'hF, 32'hFFFF_FFFC, 4'hF, 3'h7, 2'h3, {8'h1F, 32'hFFFF_FFFC, 4'hF, 3'h7, 2'h3}};
    ar_tab[2] = '{4'h0, 32'h8000_0001, 4'h0, 3'h0, 2'h0, {8'h10, 32'h8000_0001, 4'h0, 3'h0, 2'h0}};

    // Reset state
    #12;
    chk("rst_ar_valid", 64'(AR_FIFO_VALID_o), 64'd0);
    chk("rst_aw_valid", 64'(AW_FIFO_VALID_o), 64'd0);
    chk("rst_w_valid", 64'(W_FIFO_VALID_o), 64'd0);
    chk("rst_readys", 64'({ARREADY_o, AWREADY_o, WREADY_o}), 64'b111);
    chk("rst_data", 64'(AR_FIFO_DATA_o | AW_FIFO_DATA_o | 49'(W_FIFO_DATA_o)), 64'd0);
    chk("rst_credit", 64'(dut.aw_credit_q), 64'd0);
    rst = 1'b0;
    tick();

    // AR packing table
    foreach (ar_tab[i]) begin
      ARVALID_i = 1; ARID_i = ar_tab[i].id; ARADDR_i = ar_tab[i].addr;
      ARLEN_i = ar_tab[i].len; ARSIZE_i = ar_tab[i].size; ARBURST_i = ar_tab[i].burst;
      AR_FIFO_GRANT_i = (i == 0);  // grant on an empty FIFO must be ignored
      tick();
      ARVALID_i = 0; AR_FIFO_GRANT_i = 0;
      chk($sformatf("ar%0d_valid", i), 64'(AR_FIFO_VALID_o), 64'd1);
      chk($sformatf("ar%0d_data", i), 64'(AR_FIFO_DATA_o), 64'(ar_tab[i].exp));
      AR_FIFO_GRANT_i = 1;
      tick();
      AR_FIFO_GRANT_i = 0;
      chk($sformatf("ar%0d_popped", i), 64'(AR_FIFO_VALID_o), 64'd0);
    end

    // W beats ahead of their AW are held back
    for (int i = 0; i < 4; i++) begin
      w_drive(1, 32'hA0 + 32'(i), i == 3);
      W_FIFO_GRANT_i = 1;
      tick();
      chk($sformatf("w_hold%0d", i), 64'(W_FIFO_VALID_o), 64'd0);
    end
    w_drive(0, 0, 0); W_FIFO_GRANT_i = 0;
    chk("w_full_ready", 64'(WREADY_o), 64'd0);
    aw_drive(1, 4'h2, 32'h0000_2000);
    tick();
    aw_drive(0, 0, 0);
    chk("aw_valid", 64'(AW_FIFO_VALID_o), 64'd1);
    chk("aw_data", 64'(AW_FIFO_DATA_o), 64'({8'h12, 32'h0000_2000, 4'h3, 3'h2, 2'h1}));
    chk("w_still_held", 64'(W_FIFO_VALID_o), 64'd0);
    AW_FIFO_GRANT_i = 1;
    tick();
    AW_FIFO_GRANT_i = 0;
    chk("credit_after_aw", 64'(dut.aw_credit_q), 64'd1);
    chk("w_released", 64'(W_FIFO_VALID_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w_beat%0d", i), 64'(W_FIFO_DATA_o), 64'({32'hA0 + 32'(i), 4'hF, i == 3}));
      W_FIFO_GRANT_i = 1;
      tick();
      W_FIFO_GRANT_i = 0;
      if (i == 0) chk("w_ready_after_pop", 64'(WREADY_o), 64'd1);
    end
    chk("credit_back_zero", 64'(dut.aw_credit_q), 64'd0);
    chk("w_empty_valid", 64'(W_FIFO_VALID_o), 64'd0);

    // AW pop and W LAST pop at the same edge cancel
    aw_drive(1, 4'h4, 32'h0000_3000);
    tick();
    aw_drive(0, 0, 0); AW_FIFO_GRANT_i = 1;
    tick();
    AW_FIFO_GRANT_i = 0;
    aw_drive(1, 4'h5, 32'h0000_4000); w_drive(1, 32'hB0, 1);
    tick();
    aw_drive(0, 0, 0); w_drive(0, 0, 0);
    chk("both_valid", 64'({AW_FIFO_VALID_o, W_FIFO_VALID_o}), 64'b11);
    AW_FIFO_GRANT_i = 1; W_FIFO_GRANT_i = 1;
    tick();
    AW_FIFO_GRANT_i = 0; W_FIFO_GRANT_i = 0;
    chk("credit_net_zero", 64'(dut.aw_credit_q), 64'd1);
    w_drive(1, 32'hB1, 1);
    tick();
    w_drive(0, 0, 0); W_FIFO_GRANT_i = 1;
    tick();
    W_FIFO_GRANT_i = 0;
    chk("credit_drained", 64'(dut.aw_credit_q), 64'd0);

    // AR full, then push/pop at the same edge, order preserved
    for (int i = 1; i <= 4; i++) begin
      ar_drive(1, 4'(i), 32'(i));
      tick();
    end
    chk("ar_full_ready", 64'(ARREADY_o), 64'd0);
    ar_drive(1, 4'h5, 32'h5);
    chk("ar_head1", 64'(AR_FIFO_DATA_o), 64'(ar_word(4'h1, 32'h1)));
    AR_FIFO_GRANT_i = 1;
    tick();
    AR_FIFO_GRANT_i = 0;
    chk("ar_ready_after_pop", 64'(ARREADY_o), 64'd1);
    chk("ar_count3", 64'(dut.u_ar_fifo.count_q), 64'd3);
    chk("ar_head2", 64'(AR_FIFO_DATA_o), 64'(ar_word(4'h2, 32'h2)));
    AR_FIFO_GRANT_i = 1;
    tick();
    AR_FIFO_GRANT_i = 0;
    chk("ar_pushpop_count", 64'(dut.u_ar_fifo.count_q), 64'd3);
    chk("ar_pushpop_ready", 64'(ARREADY_o), 64'd1);
    ar_drive(0, 0, 0);
    for (int i = 3; i <= 5; i++) begin
      chk($sformatf("ar_order%0d", i), 64'(AR_FIFO_DATA_o), 64'(ar_word(4'(i), 32'(i))));
      if (i == 5) ar_drive(1, 4'h6, 32'h6);
      AR_FIFO_GRANT_i = 1;
      tick();
      AR_FIFO_GRANT_i = 0;
    end
    ar_drive(0, 0, 0);
    chk("ar_count1_valid", 64'(AR_FIFO_VALID_o), 64'd1);
    chk("ar_count1_head", 64'(AR_FIFO_DATA_o), 64'(ar_word(4'h6, 32'h6)));
    AR_FIFO_GRANT_i = 1;
    tick();
    AR_FIFO_GRANT_i = 0;
    chk("ar_drained", 64'(AR_FIFO_VALID_o), 64'd0);

    // Credit saturation at 15
    for (int i = 0; i < 15; i++) begin
      aw_drive(1, 4'(i), 32'(i));
      tick();
      aw_drive(0, 0, 0); AW_FIFO_GRANT_i = 1;
      tick();
      AW_FIFO_GRANT_i = 0;
    end
    chk("credit_sat", 64'(dut.aw_credit_q), 64'd15);
    aw_drive(1, 4'hF, 32'h16);
    tick();
    aw_drive(0, 0, 0); AW_FIFO_GRANT_i = 1;
    tick();
    AW_FIFO_GRANT_i = 0;
    chk("aw_blocked", 64'(AW_FIFO_VALID_o), 64'd0);
    chk("credit_no_wrap", 64'(dut.aw_credit_q), 64'd15);
    w_drive(1, 32'hC0, 1);
    tick();
    w_drive(0, 0, 0); W_FIFO_GRANT_i = 1;
    tick();
    W_FIFO_GRANT_i = 0;
    chk("credit_14", 64'(dut.aw_credit_q), 64'd14);
    chk("aw16_valid", 64'(AW_FIFO_VALID_o), 64'd1);
    chk("aw16_data", 64'(AW_FIFO_DATA_o), 64'({8'h1F, 32'h16, 4'h3, 3'h2, 2'h1}));

    // Asynchronous reset with buffered words
    w_drive(1, 32'hD0, 0);
    tick();
    w_drive(1, 32'hD1, 0); ar_drive(1, 4'h7, 32'h7);
    tick();
    w_drive(0, 0, 0); ar_drive(0, 0, 0);
    chk("pre_rst_valids", 64'({AR_FIFO_VALID_o, AW_FIFO_VALID_o, W_FIFO_VALID_o}), 64'b111);
    #2 rst = 1'b1;
    #1;
    chk("arst_valids", 64'({AR_FIFO_VALID_o, AW_FIFO_VALID_o, W_FIFO_VALID_o}), 64'b000);
    chk("arst_readys", 64'({ARREADY_o, AWREADY_o, WREADY_o}), 64'b111);
    chk("arst_credit", 64'(dut.aw_credit_q), 64'd0);
    chk("arst_data", 64'(AR_FIFO_DATA_o | AW_FIFO_DATA_o | 49'(W_FIFO_DATA_o)), 64'd0);
    tick();
    rst = 1'b0;
    ar_drive(1, 4'h9, 32'h9);
    tick();
    ar_drive(0, 0, 0);
    chk("post_rst_ar", 64'(AR_FIFO_DATA_o), 64'(ar_word(4'h9, 32'h9)));
    chk("post_rst_w", 64'(W_FIFO_VALID_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
